// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and a sysid slave.
interface sysid_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them with the expected values.
// Define SYSID_CHECK_TIMEOUT_EN to abort a read that stalls for TIMEOUT_CYCLES cycles.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1398725577,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    sysid_checker_if.master bus,
    output logic [31:0]     id_value,
    output logic [31:0]     ts_value,
    output logic            done,
    output logic            id_ok,
    output logic            ts_ok,
    output logic            timeout
);

    typedef enum logic [2:0] {StIdle, StArm, StRdId, StRdTs, StDone} state_e;

    localparam state_e ResetState = AUTO_START ? StArm : StIdle;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sysid_checker: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_e      state_q, state_d;
    logic        read_q, read_d;
    logic        address_q, address_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        xfer;
    logic        stall_hit;
    logic        entering_done;

    // Only meaningful in the read states, where read_q is always high.
    assign xfer          = ~bus.waitrequest;
    assign entering_done = (state_d == StDone) && (state_q != StDone);

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] StallLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    assign stall_hit = read_q & bus.waitrequest & (stall_cnt_q == StallLast);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_d != state_q) begin
            stall_cnt_d = '0;
        end else if (read_q && bus.waitrequest) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        timeout_d = timeout_q & (state_d == StDone);
        if (entering_done) begin
            timeout_d = stall_hit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign stall_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ResetState;
            read_q    <= 1'b0;
            address_q <= 1'b0;
            id_q      <= '0;
            ts_q      <= '0;
            done_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            address_q <= address_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            done_q    <= done_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRdId;
            StArm:   state_d = StRdId;
            StRdId: begin
                if (stall_hit) begin
                    state_d = StDone;
                end else if (xfer) begin
                    state_d = StRdTs;
                end
            end
            StRdTs:  if (stall_hit || xfer) state_d = StDone;
            StDone:  if (start) state_d = StRdId;
            default: state_d = ResetState;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        read_d    = (state_d == StRdId) || (state_d == StRdTs);
        address_d = (state_d == StRdTs);
        id_d      = id_q;
        ts_d      = ts_q;
        if (state_q == StRdId && xfer) begin
            id_d = bus.readdata;
        end
        if (state_q == StRdTs && xfer) begin
            ts_d = bus.readdata;
        end
        done_d  = (state_d == StDone);
        id_ok_d = id_ok_q & (state_d == StDone);
        ts_ok_d = ts_ok_q & (state_d == StDone);
        if (entering_done) begin
            // The timestamp compare uses the word being captured this cycle.
            id_ok_d = ~stall_hit & (id_q == EXPECTED_ID);
            ts_ok_d = ~stall_hit & (bus.readdata == EXPECTED_TS);
        end
    end

    assign bus.read    = read_q;
    assign bus.address = address_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: two instances (auto-start and manual start) with slave models.
module tb_sysid_checker;
    localparam logic [31:0] Ts = 32'd1398725577;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] ts;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
    } exp_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] id_a, ts_a, id_b, ts_b;
    logic        done_a, id_ok_a, ts_ok_a, timeout_a;
    logic        done_b, id_ok_b, ts_ok_b, timeout_b;

    logic [31:0] id_word   = 32'h0000_0000;
    logic [31:0] ts_word   = Ts;
    int unsigned stall_cfg = 0;
    int unsigned wcnt_a, wcnt_b;
    int          errors = 0;
    int          checks = 0;
    int          viol   = 0;
    int          xfer_b = 0;
    bit          mon_en = 1'b1;
    logic        stalled_p = 1'b0;
    logic        addr_p    = 1'b0;
    exp_t        sb[$];

    sysid_checker_if bus_a ();
    sysid_checker_if bus_b ();

    always #5 clock = ~clock;

    sysid_checker #(.AUTO_START(1'b1), .TIMEOUT_CYCLES(8)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .bus(bus_a),
        .id_value(id_a), .ts_value(ts_a), .done(done_a), .id_ok(id_ok_a),
        .ts_ok(ts_ok_a), .timeout(timeout_a)
    );

    sysid_checker #(.AUTO_START(1'b0), .TIMEOUT_CYCLES(8)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .bus(bus_b),
        .id_value(id_b), .ts_value(ts_b), .done(done_b), .id_ok(id_ok_b),
        .ts_ok(ts_ok_b), .timeout(timeout_b)
    );

    // Slave models: stall each read for stall_cfg cycles, zero read latency.
    assign bus_a.waitrequest = bus_a.read && (wcnt_a < stall_cfg);
    assign bus_a.readdata    = bus_a.address ? ts_word : id_word;
    assign bus_b.waitrequest = bus_b.read && (wcnt_b < stall_cfg);
    assign bus_b.readdata    = bus_b.address ? ts_word : id_word;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) wcnt_a <= 0;
        else if (bus_a.read && wcnt_a < stall_cfg) wcnt_a <= wcnt_a + 1;
        else wcnt_a <= 0;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) wcnt_b <= 0;
        else if (bus_b.read && wcnt_b < stall_cfg) wcnt_b <= wcnt_b + 1;
        else wcnt_b <= 0;
    end

    // read/address must not move in the cycle after a stalled cycle.
    always @(posedge clock) begin
        if (mon_en && reset_n && stalled_p &&
            (bus_a.read !== 1'b1 || bus_a.address !== addr_p)) viol <= viol + 1;
        stalled_p <= bus_a.read && bus_a.waitrequest;
        addr_p    <= bus_a.address;
    end

    always @(posedge clock) begin
        if (reset_n && bus_b.read && !bus_b.waitrequest) xfer_b <= xfer_b + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] id, input logic [31:0] ts,
                              input logic iok, input logic tok, input logic to);
        sb.push_back({id, ts, iok, tok, to});
    endtask

    task automatic pulse_a();
        @(negedge clock); start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clock); start_b = 1'b1;
        @(negedge clock); start_b = 1'b0;
    endtask

    // Waits (bounded) for done on instance sel, then compares against the scoreboard head.
    task automatic wait_done(input bit sel, input int bound, input string tag);
        exp_t e;
        int   n = 0;
        while (((sel ? done_b : done_a) !== 1'b1) && n < bound) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, " done"}, 32'(sel ? done_b : done_a), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " id_value"}, sel ? id_b : id_a, e.id);
            check({tag, " ts_value"}, sel ? ts_b : ts_a, e.ts);
            check({tag, " id_ok"},    32'(sel ? id_ok_b : id_ok_a), 32'(e.id_ok));
            check({tag, " ts_ok"},    32'(sel ? ts_ok_b : ts_ok_a), 32'(e.ts_ok));
            check({tag, " timeout"},  32'(sel ? timeout_b : timeout_a), 32'(e.to));
        end
    endtask

    initial begin
        int n;
        int n0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst read",     32'(bus_a.read), 32'd0);
        check("rst address",  32'(bus_a.address), 32'd0);
        check("rst id_value", id_a, 32'd0);
        check("rst ts_value", ts_a, 32'd0);
        check("rst done",     32'(done_a), 32'd0);
        check("rst id_ok",    32'(id_ok_a), 32'd0);
        check("rst ts_ok",    32'(ts_ok_a), 32'd0);
        check("rst timeout",  32'(timeout_a), 32'd0);
        check("rst b read",   32'(bus_b.read), 32'd0);

        // Auto-start: done on the third edge after release
        expect_seq(32'h0, Ts, 1'b1, 1'b1, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("e1 read",    32'(bus_a.read), 32'd1);
        check("e1 address", 32'(bus_a.address), 32'd0);
        @(posedge clock); #1;
        check("e2 read",    32'(bus_a.read), 32'd1);
        check("e2 address", 32'(bus_a.address), 32'd1);
        check("e2 done",    32'(done_a), 32'd0);
        @(posedge clock); #1;
        check("e3 read",    32'(bus_a.read), 32'd0);
        wait_done(1'b0, 0, "auto");
        check("b idle read", 32'(bus_b.read), 32'd0);
        check("b idle done", 32'(done_b), 32'd0);

        // Wrong ID word
        id_word = 32'h0000_0001;
        expect_seq(32'h1, Ts, 1'b0, 1'b1, 1'b0);
        pulse_a();
        check("idmis clear done", 32'(done_a), 32'd0);
        check("idmis clear ok",   32'(id_ok_a), 32'd0);
        check("idmis read",       32'(bus_a.read), 32'd1);
        wait_done(1'b0, 10, "idmis");

        // Five stall cycles per read: done on the 13th edge after release
        id_word   = 32'h0;
        stall_cfg = 5;
        expect_seq(32'h0, Ts, 1'b1, 1'b1, 1'b0);
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        check("stall e12 done",    32'(done_a), 32'd0);
        check("stall e12 address", 32'(bus_a.address), 32'd1);
        @(posedge clock); #1;
        wait_done(1'b0, 0, "stall13");
        check("stall stable", 32'(viol), 32'd0);

        // Reset during RD_TS
        pulse_a();
        n = 0;
        while (bus_a.address !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("midrd in rd_ts", 32'(bus_a.address), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrd read", 32'(bus_a.read), 32'd0);
        check("midrd done", 32'(done_a), 32'd0);
        check("midrd ok",   32'(id_ok_a | ts_ok_a), 32'd0);
        check("midrd id",   id_a, 32'd0);
        stall_cfg = 0;
        expect_seq(32'h0, Ts, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock); reset_n = 1'b1;
        wait_done(1'b0, 10, "postrst");

        // Manual start from IDLE
        repeat (2) @(posedge clock);
        #1;
        check("b still idle", 32'(bus_b.read), 32'd0);
        expect_seq(32'h0, Ts, 1'b1, 1'b1, 1'b0);
        n0 = xfer_b;
        pulse_b();
        check("b1 read",    32'(bus_b.read), 32'd1);
        check("b1 address", 32'(bus_b.address), 32'd0);
        wait_done(1'b1, 10, "b1");
        check("b1 reads", 32'(xfer_b - n0), 32'd2);

        // Restart from DONE, second start during RD_ID ignored
        id_word   = 32'h0000_1234;
        stall_cfg = 3;
        expect_seq(32'h1234, Ts, 1'b0, 1'b1, 1'b0);
        n0 = xfer_b;
        pulse_b();
        check("b2 clear done",  32'(done_b), 32'd0);
        check("b2 clear ts_ok", 32'(ts_ok_b), 32'd0);
        pulse_b();
        check("b2 rd_id read",    32'(bus_b.read), 32'd1);
        check("b2 rd_id address", 32'(bus_b.address), 32'd0);
        wait_done(1'b1, 30, "b2");
        check("b2 reads", 32'(xfer_b - n0), 32'd2);
        repeat (3) @(posedge clock);
        #1;
        check("b2 done sticky", 32'(done_b), 32'd1);
        check("b2 no extra",    32'(xfer_b - n0), 32'd2);

`ifdef SYSID_CHECK_TIMEOUT_EN
        // Stuck waitrequest aborts after 8 stall cycles
        mon_en    = 1'b0;
        stall_cfg = 1000;
        expect_seq(32'h0, Ts, 1'b0, 1'b0, 1'b1);
        pulse_a();
        repeat (7) @(posedge clock);
        #1;
        check("to e7 read", 32'(bus_a.read), 32'd1);
        @(posedge clock); #1;
        check("to e8 read", 32'(bus_a.read), 32'd0);
        wait_done(1'b0, 0, "timeout");
        stall_cfg = 0;
        expect_seq(32'h0, Ts, 1'b1, 1'b1, 1'b0);
        pulse_a();
        check("to clear", 32'(timeout_a), 32'd0);
        wait_done(1'b0, 10, "after_to");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
